// File: rtl/alu_job_master_if.sv
// Bus master port bundle for alu_job_master: request/write/address/data out,
// grant/read data back from the ALU/RAM bus.
interface alu_job_master_if;
   logic        M_req;
   logic        M_wr;
   logic [7:0]  M_addr;
   logic [31:0] M_dout;
   logic        M_grant;
   logic [31:0] M_din;

   modport master (
      output M_req, M_wr, M_addr, M_dout,
      input  M_grant, M_din
   );

   modport slave (
      input  M_req, M_wr, M_addr, M_dout,
      output M_grant, M_din
   );
endinterface

// File: rtl/alu_job_master.sv
// Batch ALU job master: fetches A/B/opcode per job from RAM, drives the ALU, polls, stores result.
// Optional feature macro: POLL_TIMEOUT_EN (bounded polling, 32'hDEAD_BEEF result and sticky error).
module alu_job_master #(
   parameter logic [7:0] ALU_BASE = 8'h00,
   parameter logic [7:0] RAM_BASE = 8'h20,
   parameter logic [7:0] TIMEOUT  = 8'd255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [3:0]           job_count,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   alu_job_master_if.master     bus
);

   localparam logic [7:0]  OFS_OPA  = 8'd0;
   localparam logic [7:0]  OFS_OPB  = 8'd1;
   localparam logic [7:0]  OFS_OPC  = 8'd2;
   localparam logic [7:0]  OFS_GO   = 8'd3;
   localparam logic [7:0]  OFS_STAT = 8'd4;
   localparam logic [7:0]  OFS_RES  = 8'd5;
   localparam logic [31:0] FAIL_RES = 32'hDEAD_BEEF;

   typedef enum logic [3:0] {
      S_IDLE, S_RD_A, S_RD_B, S_RD_C, S_WR_A, S_WR_B, S_WR_C,
      S_WR_GO, S_POLL, S_RD_RES, S_WR_RES, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        cap_q, cap_d;
   logic        capc_q, capc_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] opc_q, opc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        req_q, req_d;
   logic        wr_q, wr_d;
   logic [7:0]  addr_q, addr_d;
   logic [31:0] dout_q, dout_d;
   logic        xfer_s;
   logic [3:0]  k_inc_s;
`ifdef POLL_TIMEOUT_EN
   logic [7:0]  polls_q, polls_d;
`endif

   function automatic logic [7:0] ram_addr(input logic [2:0] k, input logic [1:0] w);
      return RAM_BASE + {3'b000, k, w};
   endfunction

   assign xfer_s  = req_q & bus.M_grant;
   assign k_inc_s = k_q + 4'd1;

   // Read states use cap_q as their capture half; the opcode read (RD_C) captures
   // while WR_A is already being issued, tracked separately by capc_q.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      capc_d  = 1'b0;
      k_d     = k_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      opc_d   = capc_q ? bus.M_din : opc_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;
      req_d   = req_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
`ifdef POLL_TIMEOUT_EN
      polls_d = polls_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               k_d   = 4'd0;
               err_d = 1'b0;
               cnt_d = (job_count > 4'd8) ? 4'd8 : job_count;
               if (job_count == 4'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_RD_A;
                  busy_d  = 1'b1;
                  req_d   = 1'b1;
                  wr_d    = 1'b0;
                  addr_d  = ram_addr(3'd0, 2'd0);
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         S_RD_A: begin
            if (cap_q) begin
               opa_d   = bus.M_din;
               cap_d   = 1'b0;
               state_d = S_RD_B;
               req_d   = 1'b1;
               addr_d  = ram_addr(k_q[2:0], 2'd1);
            end else if (xfer_s) begin
               cap_d = 1'b1;
               req_d = 1'b0;
            end else begin
               req_d = 1'b1;
            end
         end
         S_RD_B: begin
            if (cap_q) begin
               opb_d   = bus.M_din;
               cap_d   = 1'b0;
               state_d = S_RD_C;
               req_d   = 1'b1;
               addr_d  = ram_addr(k_q[2:0], 2'd2);
            end else if (xfer_s) begin
               cap_d = 1'b1;
               req_d = 1'b0;
            end else begin
               req_d = 1'b1;
            end
         end
         S_RD_C: begin
            if (xfer_s) begin
               capc_d  = 1'b1;
               state_d = S_WR_A;
               wr_d    = 1'b1;
               addr_d  = ALU_BASE + OFS_OPA;
               dout_d  = opa_q;
            end else begin
               capc_d = 1'b0;
            end
         end
         S_WR_A: begin
            if (xfer_s) begin
               state_d = S_WR_B;
               addr_d  = ALU_BASE + OFS_OPB;
               dout_d  = opb_q;
            end else begin
               state_d = S_WR_A;
            end
         end
         S_WR_B: begin
            if (xfer_s) begin
               state_d = S_WR_C;
               addr_d  = ALU_BASE + OFS_OPC;
               dout_d  = opc_q;
            end else begin
               state_d = S_WR_B;
            end
         end
         S_WR_C: begin
            if (xfer_s) begin
               state_d = S_WR_GO;
               addr_d  = ALU_BASE + OFS_GO;
               dout_d  = 32'h0000_0001;
            end else begin
               state_d = S_WR_C;
            end
         end
         S_WR_GO: begin
            if (xfer_s) begin
               state_d = S_POLL;
               wr_d    = 1'b0;
               addr_d  = ALU_BASE + OFS_STAT;
`ifdef POLL_TIMEOUT_EN
               polls_d = 8'd0;
`endif
            end else begin
               state_d = S_WR_GO;
            end
         end
         S_POLL: begin
            if (cap_q) begin
               cap_d = 1'b0;
               req_d = 1'b1;
               if (bus.M_din[0]) begin
                  state_d = S_RD_RES;
                  addr_d  = ALU_BASE + OFS_RES;
               end else begin
`ifdef POLL_TIMEOUT_EN
                  if (polls_q == (TIMEOUT - 8'd1)) begin
                     err_d   = 1'b1;
                     state_d = S_WR_RES;
                     wr_d    = 1'b1;
                     addr_d  = ram_addr(k_q[2:0], 2'd3);
                     dout_d  = FAIL_RES;
                  end else begin
                     polls_d = polls_q + 8'd1;
                  end
`else
                  state_d = S_POLL;
`endif
               end
            end else if (xfer_s) begin
               cap_d = 1'b1;
               req_d = 1'b0;
            end else begin
               req_d = 1'b1;
            end
         end
         S_RD_RES: begin
            if (cap_q) begin
               cap_d   = 1'b0;
               state_d = S_WR_RES;
               req_d   = 1'b1;
               wr_d    = 1'b1;
               addr_d  = ram_addr(k_q[2:0], 2'd3);
               dout_d  = bus.M_din;
            end else if (xfer_s) begin
               cap_d = 1'b1;
               req_d = 1'b0;
            end else begin
               req_d = 1'b1;
            end
         end
         S_WR_RES: begin
            if (xfer_s) begin
               if (k_inc_s < cnt_q) begin
                  k_d     = k_inc_s;
                  state_d = S_RD_A;
                  wr_d    = 1'b0;
                  addr_d  = ram_addr(k_inc_s[2:0], 2'd0);
               end else begin
                  state_d = S_DONE;
                  req_d   = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               state_d = S_WR_RES;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cap_d   = 1'b0;
            req_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered bus/status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cap_q   <= 1'b0;
         capc_q  <= 1'b0;
         k_q     <= 4'd0;
         cnt_q   <= 4'd0;
         opa_q   <= 32'h0;
         opb_q   <= 32'h0;
         opc_q   <= 32'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= 8'h00;
         dout_q  <= 32'h0;
`ifdef POLL_TIMEOUT_EN
         polls_q <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         capc_q  <= capc_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         opc_q   <= opc_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         req_q   <= req_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         dout_q  <= dout_d;
`ifdef POLL_TIMEOUT_EN
         polls_q <= polls_d;
`endif
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign bus.M_req  = req_q;
   assign bus.M_wr   = wr_q;
   assign bus.M_addr = addr_q;
   assign bus.M_dout = dout_q;
`ifdef POLL_TIMEOUT_EN
   assign error      = err_q;
`else
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_job_master.sv
// Self-checking bench for alu_job_master: RAM + ALU slave model on the bus,
// reference results computed from the job layout in RAM.
module tb_alu_job_master;

   localparam logic [7:0] RAM_BASE = 8'h20;
`ifdef POLL_TIMEOUT_EN
   localparam int TMO = 4;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] job_count;
   logic       busy, done, error;

   alu_job_master_if bus();

   alu_job_master #(.TIMEOUT(8'd4)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .job_count (job_count),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .bus       (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [31:0] ram  [32];
   logic [31:0] pre  [32];
   logic [31:0] expv [32];
   logic        load_en;
   int          poll_lat;
   int          wr_cnt, req_cnt, res_wr_cnt, stat_cnt;
   logic [31:0] alu_a, alu_b, alu_c, alu_res;
   logic [7:0]  ram_off;
   logic        in_ram;

   assign ram_off = bus.M_addr - RAM_BASE;
   assign in_ram  = (ram_off < 8'd32);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] op);
      case (op[1:0])
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a * b;
         default: return a ^ b;
      endcase
   endfunction

   // RAM slave, ALU slave and bus activity counters.
   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < 32; i++) ram[i] <= pre[i];
         wr_cnt     <= 0;
         req_cnt    <= 0;
         res_wr_cnt <= 0;
      end else begin
         if (bus.M_req) req_cnt <= req_cnt + 1;
         if (bus.M_req && bus.M_grant) begin
            if (bus.M_wr) begin
               wr_cnt <= wr_cnt + 1;
               if (in_ram) begin
                  ram[ram_off[4:0]] <= bus.M_dout;
                  if (ram_off[1:0] == 2'd3) res_wr_cnt <= res_wr_cnt + 1;
               end else begin
                  case (bus.M_addr)
                     8'd0: alu_a <= bus.M_dout;
                     8'd1: alu_b <= bus.M_dout;
                     8'd2: alu_c <= bus.M_dout;
                     8'd3: begin
                        alu_res  <= ref_alu(alu_a, alu_b, alu_c);
                        stat_cnt <= 0;
                     end
                     default: ;
                  endcase
               end
            end else begin
               if (in_ram) bus.M_din <= ram[ram_off[4:0]];
               else if (bus.M_addr == 8'd4) begin
                  bus.M_din <= {31'd0, (poll_lat != 0) && (stat_cnt + 1 >= poll_lat)};
                  stat_cnt  <= stat_cnt + 1;
               end
               else if (bus.M_addr == 8'd5) bus.M_din <= alu_res;
               else bus.M_din <= 32'h0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < 32; i++)
         pre[i] = ((i % 4) == 2) ? 32'($urandom_range(0, 3)) : $urandom;
   endtask

   task automatic prep();
      load_en = 1'b1;
      tick();
      load_en = 1'b0;
   endtask

   task automatic build_exp(input int cnt);
      int n;
      n = (cnt > 8) ? 8 : cnt;
      for (int i = 0; i < 32; i++) expv[i] = pre[i];
      for (int j = 0; j < n; j++)
         expv[4*j+3] = ref_alu(pre[4*j], pre[4*j+1], pre[4*j+2]);
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < 32; i++)
         check($sformatf("%s_ram%0d", tag, i), ram[i], expv[i]);
   endtask

   // Runs one batch; optionally drops grant for 3 cycles during the WR_B write.
   task automatic run_batch(input logic [3:0] cnt, input bit stall_en,
                            output int t_done, output int n_busy, output int n_done);
      int          stall_left;
      bit          stalled;
      logic [7:0]  ha;
      logic [31:0] hd;
      t_done = -1; n_busy = 0; n_done = 0; stall_left = 0; stalled = 1'b0;
      ha = 8'h00; hd = 32'h0;
      job_count = cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 3000; c++) begin
         if (busy) n_busy++;
         if (done) begin
            n_done++;
            if (t_done < 0) t_done = c;
         end
         if (t_done >= 0 && c >= t_done + 3) break;
         if (stall_left > 0) begin
            check("stall_addr", bus.M_addr, ha);
            check("stall_dout", bus.M_dout, hd);
            check("stall_req",  bus.M_req,  1'b1);
            check("stall_wr",   bus.M_wr,   1'b1);
            stall_left--;
            if (stall_left == 0) bus.M_grant = 1'b1;
         end else if (stall_en && !stalled && bus.M_req && bus.M_wr && bus.M_addr == 8'h01) begin
            stalled = 1'b1; stall_left = 3;
            ha = bus.M_addr; hd = bus.M_dout;
            bus.M_grant = 1'b0;
         end
         tick();
      end
      if (t_done < 0) check("done_seen", 32'd0, 32'd1);
   endtask

   int          td, nb, nd, jc, n_eff, lim;
   bit          hit;

   initial begin
      reset = 1'b1; start = 1'b0; job_count = 4'd0; load_en = 1'b0;
      bus.M_grant = 1'b1; poll_lat = 1;
      wr_cnt = 0; req_cnt = 0; res_wr_cnt = 0; stat_cnt = 0;
      alu_a = 32'h0; alu_b = 32'h0; alu_c = 32'h0; alu_res = 32'h0;
      repeat (3) tick();
      check("rst_busy",  busy,  1'b0);
      check("rst_done",  done,  1'b0);
      check("rst_error", error, 1'b0);
      check("rst_req",   bus.M_req,  1'b0);
      check("rst_wr",    bus.M_wr,   1'b0);
      check("rst_addr",  bus.M_addr, 8'h00);
      check("rst_dout",  bus.M_dout, 32'h0);
      reset = 1'b0;
      tick();

      // single MUL job, done on first poll
      fill_random();
      pre[0] = 32'd5; pre[1] = 32'd7; pre[2] = 32'd2; pre[3] = 32'd0;
      poll_lat = 1;
      prep();
      build_exp(1);
      run_batch(4'd1, 1'b0, td, nb, nd);
      check("t1_result", ram[3], 32'd35);
      check("t1_done_cycle", td, 15);
      check("t1_busy_cycles", nb, 14);
      check("t1_done_count", nd, 1);
      check("t1_writes", wr_cnt, 5);
      check("t1_error", error, 1'b0);
      check_ram("t1");

      // random full and partial batches
      for (int it = 0; it < 3; it++) begin
         fill_random();
         poll_lat = $urandom_range(1, 3);
         jc = (it == 0) ? 8 : $urandom_range(1, 15);
         n_eff = (jc > 8) ? 8 : jc;
         prep();
         build_exp(jc);
         run_batch(4'(jc), 1'b0, td, nb, nd);
         check($sformatf("rnd%0d_done_count", it), nd, 1);
         check($sformatf("rnd%0d_writes", it), wr_cnt, 5 * n_eff);
         check($sformatf("rnd%0d_res_writes", it), res_wr_cnt, n_eff);
         check($sformatf("rnd%0d_req_idle", it), bus.M_req, 1'b0);
         if (n_eff == 8) check("rnd_final_addr", bus.M_addr, RAM_BASE + 8'h1F);
         else check("rnd_final_addr", bus.M_addr, RAM_BASE + 8'(4 * n_eff - 1));
         check_ram($sformatf("rnd%0d", it));
      end

      // grant dropped during WR_B
      fill_random();
      poll_lat = 1;
      prep();
      build_exp(1);
      run_batch(4'd1, 1'b1, td, nb, nd);
      check("stall_done_cycle", td, 18);
      check("stall_writes", wr_cnt, 5);
      check("stall_result", ram[3], expv[3]);

      // zero jobs
      prep();
      run_batch(4'd0, 1'b0, td, nb, nd);
      check("zero_done_cycle", td, 1);
      check("zero_busy_cycles", nb, 0);
      check("zero_done_count", nd, 1);
      check("zero_req_cycles", req_cnt, 0);

      // clamp 12 -> 8
      fill_random();
      poll_lat = $urandom_range(1, 3);
      prep();
      build_exp(12);
      run_batch(4'd12, 1'b0, td, nb, nd);
      check("clamp_writes", wr_cnt, 40);
      check("clamp_final_addr", bus.M_addr, RAM_BASE + 8'h1F);
      check_ram("clamp");

      // reset during POLL of job 2
      fill_random();
      poll_lat = 4;
      prep();
      job_count = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      hit = 1'b0;
      lim = 0;
      while (!hit && lim < 1000) begin
         if (res_wr_cnt == 2 && bus.M_req && !bus.M_wr && bus.M_addr == 8'h04) hit = 1'b1;
         else begin
            tick();
            lim++;
         end
      end
      check("rstmid_reached_poll", hit, 1'b1);
      reset = 1'b1;
      tick();
      check("rstmid_busy",  busy,  1'b0);
      check("rstmid_done",  done,  1'b0);
      check("rstmid_error", error, 1'b0);
      check("rstmid_req",   bus.M_req,  1'b0);
      check("rstmid_wr",    bus.M_wr,   1'b0);
      check("rstmid_addr",  bus.M_addr, 8'h00);
      check("rstmid_dout",  bus.M_dout, 32'h0);
      reset = 1'b0;
      tick();
      fill_random();
      poll_lat = 1;
      prep();
      build_exp(3);
      run_batch(4'd3, 1'b0, td, nb, nd);
      check("rerun_writes", wr_cnt, 15);
      check_ram("rerun");

`ifdef POLL_TIMEOUT_EN
      // ALU never completes
      fill_random();
      poll_lat = 0;
      prep();
      run_batch(4'd1, 1'b0, td, nb, nd);
      check("tmo_result", ram[3], 32'hDEAD_BEEF);
      check("tmo_polls", stat_cnt, TMO);
      check("tmo_error", error, 1'b1);
      tick();
      tick();
      check("tmo_error_sticky", error, 1'b1);
      poll_lat = 1;
      job_count = 4'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("tmo_error_cleared", error, 1'b0);
      tick();
`else
      check("error_tied_low", error, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
